// File: rtl/tx_pkg.sv
// Shared definitions for the transmit fire sequencer and the TX_Switch pulser.
// Holds the sequencer state encoding and the timing constants both blocks agree on.
package tx_pkg;

    localparam int TX_REG_WIDTH    = 8;
    localparam int TX_PRI_OVERHEAD = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT,
        ST_FINISH
    } seq_state_e;

endpackage

// File: rtl/rx_gate_gen.sv
// Receive-gate generator: after each start strobe, raises o_rx_en for a delayed
// window that is clipped to the current pulse-repetition interval.
module rx_gate_gen #(
    parameter int PRI_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_clear,
    input  logic                 i_start,
    input  logic [PRI_WIDTH-1:0] i_rx_delay,
    input  logic [PRI_WIDTH-1:0] i_rx_len,
    input  logic [PRI_WIDTH-1:0] i_pri_eff,
    output logic                 o_rx_en
);

    logic [PRI_WIDTH-1:0] r_off;
    logic                 r_active;
    logic                 r_rx_en;
    logic [PRI_WIDTH-1:0] w_off_nxt;
    logic                 w_act_nxt;
    logic                 w_in_win;

    // i_start arrives one cycle before START is visible, so the offset computed
    // here is the offset of the cycle that r_rx_en will be presented in.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_off_nxt = r_off;
        w_act_nxt = r_active;
        w_in_win  = 1'b0;
        if (i_start) begin
            w_off_nxt = '0;
            w_act_nxt = 1'b1;
        end else if (r_active) begin
            if (r_off >= i_pri_eff - PRI_WIDTH'(1)) begin
                w_act_nxt = 1'b0;
            end else begin
                w_off_nxt = r_off + PRI_WIDTH'(1);
            end
        end
        if (w_act_nxt && (w_off_nxt >= i_rx_delay) && (w_off_nxt < i_pri_eff)) begin
            w_in_win = (w_off_nxt - i_rx_delay) < i_rx_len;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_off    <= '0;
            r_active <= 1'b0;
            r_rx_en  <= 1'b0;
        end else begin
            r_off    <= w_off_nxt;
            r_active <= w_act_nxt;
            r_rx_en  <= w_in_win;
        end
    end

    assign o_rx_en = r_rx_en;

endmodule

// File: rtl/tx_fire_sequencer.sv
// Pulse-repetition sequencer driving TX_Switch.START: fires num_shots pulses at
// max(pri_len, pulser minimum) spacing and gates the receive path after each shot.
module tx_fire_sequencer
    import tx_pkg::*;
#(
    parameter int REG_WIDTH = TX_REG_WIDTH,
    parameter int PRI_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 GO,
    input  logic                 ABORT,
    input  logic [REG_WIDTH-1:0] num_shots,
    input  logic [PRI_WIDTH-1:0] pri_len,
    input  logic [REG_WIDTH-1:0] init_delay,
    input  logic [REG_WIDTH-1:0] tx_len,
    input  logic [REG_WIDTH-1:0] damp_len,
    input  logic [PRI_WIDTH-1:0] rx_delay,
    input  logic [PRI_WIDTH-1:0] rx_len,
    output logic                 START,
    output logic                 RX_EN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [REG_WIDTH-1:0] shot_cnt
);

    seq_state_e           r_state;
    seq_state_e           w_next;
    logic [REG_WIDTH-1:0] r_num_shots;
    logic [REG_WIDTH-1:0] r_shot_cnt;
    logic [PRI_WIDTH-1:0] r_pri_eff;
    logic [PRI_WIDTH-1:0] r_rx_delay;
    logic [PRI_WIDTH-1:0] r_rx_len;
    logic [PRI_WIDTH-1:0] r_pri_cnt;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_done;
    logic [PRI_WIDTH-1:0] w_min_pri;
    logic [PRI_WIDTH-1:0] w_pri_eff;
    logic                 w_accept;
    logic                 w_idle;
    logic                 w_rx_en;

    assign w_min_pri = PRI_WIDTH'(init_delay) + PRI_WIDTH'(tx_len) + PRI_WIDTH'(damp_len)
                     + PRI_WIDTH'(TX_PRI_OVERHEAD);
    assign w_pri_eff = (pri_len > w_min_pri) ? pri_len : w_min_pri;
    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = w_idle && GO && !ABORT;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (GO) w_next = (num_shots != '0) ? ST_FIRE : ST_FINISH;
            ST_FIRE:   w_next = ST_WAIT;
            ST_WAIT:   if (r_pri_cnt == r_pri_eff - PRI_WIDTH'(1))
                           w_next = (r_shot_cnt < r_num_shots) ? ST_FIRE : ST_FINISH;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (ABORT) w_next = ST_IDLE;
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_num_shots <= '0;
            r_shot_cnt  <= '0;
            r_pri_eff   <= '0;
            r_rx_delay  <= '0;
            r_rx_len    <= '0;
            r_pri_cnt   <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_state <= w_next;
            r_start <= (w_next == ST_FIRE);
            r_busy  <= (w_next == ST_FIRE) || (w_next == ST_WAIT);
            r_done  <= (w_next == ST_FINISH);
            if (w_accept) begin
                r_num_shots <= num_shots;
                r_pri_eff   <= w_pri_eff;
                r_rx_delay  <= rx_delay;
                r_rx_len    <= rx_len;
                r_shot_cnt  <= '0;
            end
            if (r_state == ST_FIRE && !ABORT) r_shot_cnt <= r_shot_cnt + REG_WIDTH'(1);
            if (r_state == ST_FIRE) begin
                r_pri_cnt <= PRI_WIDTH'(1);
            end else if (r_state == ST_WAIT) begin
                r_pri_cnt <= r_pri_cnt + PRI_WIDTH'(1);
            end
        end
    end

    // The first shot's strobe is issued while still in IDLE, before the shadows load.
    rx_gate_gen #(
        .PRI_WIDTH (PRI_WIDTH)
    ) u_rx_gate (
        .i_clk      (CLK),
        .i_clear    (RESET | ABORT),
        .i_start    (w_next == ST_FIRE),
        .i_rx_delay (w_idle ? rx_delay  : r_rx_delay),
        .i_rx_len   (w_idle ? rx_len    : r_rx_len),
        .i_pri_eff  (w_idle ? w_pri_eff : r_pri_eff),
        .o_rx_en    (w_rx_en)
    );

    assign START    = r_start;
    assign RX_EN    = w_rx_en;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign shot_cnt = r_shot_cnt;

endmodule

// File: tb/tb_tx_fire_sequencer.sv
// Self-checking bench for tx_fire_sequencer: directed table, corner sequences,
// and randomized sequences scored against a shot-timeline model.
module tb_tx_fire_sequencer;

    localparam int RW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst, go, abort;
    logic [RW-1:0] num_shots, init_delay, tx_len, damp_len, shot_cnt;
    logic [PW-1:0] pri_len, rx_delay, rx_len;
    logic          start, rx_en, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tx_fire_sequencer #(.REG_WIDTH(RW), .PRI_WIDTH(PW)) dut (
        .CLK(clk), .RESET(rst), .GO(go), .ABORT(abort),
        .num_shots(num_shots), .pri_len(pri_len),
        .init_delay(init_delay), .tx_len(tx_len), .damp_len(damp_len),
        .rx_delay(rx_delay), .rx_len(rx_len),
        .START(start), .RX_EN(rx_en), .BUSY(busy), .DONE(done), .shot_cnt(shot_cnt)
    );

    typedef struct {
        int n, idly, txl, dmp, pri, d, len;
        int done_at, n_start, n_busy, n_rx, rx_first, rx_last, shots;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_inputs(input int n, input int i, input int t, input int dm,
                              input int p, input int d, input int l);
        num_shots  = RW'(n);
        init_delay = RW'(i);
        tx_len     = RW'(t);
        damp_len   = RW'(dm);
        pri_len    = PW'(p);
        rx_delay   = PW'(d);
        rx_len     = PW'(l);
    endtask

    function automatic int pri_eff_of(int p, int i, int t, int dm);
        int mn;
        mn = i + t + dm + 2;
        return (p > mn) ? p : mn;
    endfunction

    // Expected {START, RX_EN, BUSY, DONE} at rel cycles after the cycle following GO.
    function automatic logic [3:0] model(int rel, int n, int pe, int d, int l);
        int ph;
        if (rel < 0) return 4'b0000;
        if (rel < n * pe) begin
            ph = rel % pe;
            return {ph == 0, (ph >= d) && (ph - d < l), 1'b1, 1'b0};
        end
        return {3'b000, rel == n * pe};
    endfunction

    initial begin
        vec_t vecs[8];
        int   obs_done, cnt_start, cnt_busy, cnt_rx, cnt_done, rx_first, rx_last;

        vecs[0] = '{3, 5, 7, 3, 40,  0,     0, 121, 3, 120,  0, -1, -1, 3};
        vecs[1] = '{3, 5, 7, 3,  4,  0,     0,  52, 3,  51,  0, -1, -1, 3};
        vecs[2] = '{1, 5, 7, 3, 40, 10,    40,  41, 1,  40, 30, 11, 40, 1};
        vecs[3] = '{0, 5, 7, 3, 40,  0,     0,   1, 0,   0,  0, -1, -1, 0};
        vecs[4] = '{2, 5, 7, 3, 40,  0,     1,  81, 2,  80,  2,  1, 41, 2};
        vecs[5] = '{1, 5, 7, 3,  4, 17,     5,  18, 1,  17,  0, -1, -1, 1};
        vecs[6] = '{2, 0, 0, 0, 20,  5, 65535,  41, 2,  40, 30,  6, 40, 2};
        vecs[7] = '{3, 0, 0, 0,  0,  0,     5,   7, 3,   6,  6,  1,  6, 3};

        rst = 1'b1; go = 1'b0; abort = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("reset_outputs", {start, rx_en, busy, done}, 0);
        check("reset_shot_cnt", shot_cnt, 0);
        rst = 1'b0;
        step();

        // Directed table; pri_len is scrambled mid-sequence to prove the shadows hold.
        for (int v = 0; v < 8; v++) begin
            set_inputs(vecs[v].n, vecs[v].idly, vecs[v].txl, vecs[v].dmp,
                       vecs[v].pri, vecs[v].d, vecs[v].len);
            obs_done = -1; cnt_start = 0; cnt_busy = 0; cnt_rx = 0; cnt_done = 0;
            rx_first = -1; rx_last = -1;
            go = 1'b1;
            for (int p = 1; p <= vecs[v].done_at + 3; p++) begin
                step();
                go = 1'b0;
                pri_len = PW'($urandom_range(0, 300));
                if (start) cnt_start++;
                if (busy) cnt_busy++;
                if (done) begin
                    cnt_done++;
                    if (obs_done < 0) obs_done = p;
                end
                if (rx_en) begin
                    cnt_rx++;
                    if (rx_first < 0) rx_first = p;
                    rx_last = p;
                end
            end
            check($sformatf("v%0d_done_at", v), obs_done, vecs[v].done_at);
            check($sformatf("v%0d_done_cnt", v), cnt_done, 1);
            check($sformatf("v%0d_starts", v), cnt_start, vecs[v].n_start);
            check($sformatf("v%0d_busy", v), cnt_busy, vecs[v].n_busy);
            check($sformatf("v%0d_rx_cnt", v), cnt_rx, vecs[v].n_rx);
            check($sformatf("v%0d_rx_first", v), rx_first, vecs[v].rx_first);
            check($sformatf("v%0d_rx_last", v), rx_last, vecs[v].rx_last);
            check($sformatf("v%0d_shot_cnt", v), shot_cnt, vecs[v].shots);
        end

        // num_shots=0: GO in FINISH ignored, GO in following IDLE accepted.
        set_inputs(0, 5, 7, 3, 40, 0, 0);
        go = 1'b1;
        step();
        check("zero_done_first", {start, busy, done}, 3'b001);
        step();
        check("zero_go_in_finish_ignored", {start, busy, done}, 3'b000);
        step();
        go = 1'b0;
        check("zero_go_in_idle_accepted", {start, busy, done}, 3'b001);
        step();
        check("zero_quiet_after", {start, rx_en, busy, done}, 0);

        // ABORT during the second shot's RX window.
        set_inputs(5, 5, 7, 3, 40, 0, 40);
        cnt_start = 0;
        go = 1'b1;
        for (int p = 1; p <= 50; p++) begin
            step();
            go = 1'b0;
            if (start) cnt_start++;
        end
        check("abort_starts_before", cnt_start, 2);
        check("abort_rx_live_before", rx_en, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_outputs_low", {start, rx_en, busy, done}, 0);
        check("abort_shot_cnt_held", shot_cnt, 2);
        cnt_start = 0;
        for (int p = 0; p < 9; p++) begin
            step();
            if (start || rx_en || busy || done) cnt_start++;
        end
        check("abort_stays_idle", cnt_start, 0);
        go = 1'b1;
        step();
        go = 1'b0;
        check("abort_restart", {start, busy, done}, 3'b110);
        check("abort_restart_cnt", shot_cnt, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_fire_holds", shot_cnt, 0);

        // RESET mid-sequence.
        go = 1'b1;
        for (int p = 1; p <= 20; p++) begin
            step();
            go = 1'b0;
        end
        check("reset_mid_busy_before", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_mid_outputs", {start, rx_en, busy, done}, 0);
        check("reset_mid_shot_cnt", shot_cnt, 0);
        step();

        // Randomized sequences against the timeline model, with junk on inputs mid-run.
        for (int s = 0; s < 24; s++) begin
            int n, i, t, dm, p, d, l, pe, total, errs;
            n  = $urandom_range(0, 4);
            i  = $urandom_range(0, 15);
            t  = $urandom_range(0, 15);
            dm = $urandom_range(0, 15);
            p  = $urandom_range(0, 70);
            d  = $urandom_range(0, 50);
            l  = $urandom_range(0, 50);
            pe = pri_eff_of(p, i, t, dm);
            total = n * pe;
            set_inputs(n, i, t, dm, p, d, l);
            go = 1'b1;
            for (int rel = 0; rel <= total + 1; rel++) begin
                step();
                check($sformatf("rnd%0d_rel%0d_outs", s, rel),
                      {start, rx_en, busy, done}, model(rel, n, pe, d, l));
                go = (rel <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
                set_inputs($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 255), $urandom_range(0, 500),
                           $urandom_range(0, 500), $urandom_range(0, 500));
            end
            check($sformatf("rnd%0d_shot_cnt", s), shot_cnt, n);
            errs = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_fire_sequencer.md
# tx_fire_sequencer

Pulse-repetition sequencer that sits directly upstream of the transmit pulser (TX_Switch) and drives its START input. On a GO command it fires a programmable number of shots at a fixed pulse-repetition interval (PRI). It enforces a minimum PRI derived from the pulser's own timing registers. After every shot it produces a receive-gate window (RX_EN) for the capture path.

## Interface
- REG_WIDTH, 8: width of count and timing registers shared with TX_Switch
- PRI_WIDTH, 16: width of PRI and RX-window counters; must be ≥ REG_WIDTH+2
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- GO  in  1  start a sequence; sampled only in IDLE
- ABORT  in  1  synchronous stop; takes effect in any state
- num_shots  in  REG_WIDTH  shots per sequence
- pri_len  in  PRI_WIDTH  requested PRI in clocks
- init_delay, tx_len, damp_len  in  REG_WIDTH each  same values fed to TX_Switch, used for the PRI floor
- rx_delay  in  PRI_WIDTH  RX_EN start offset from START
- rx_len  in  PRI_WIDTH  RX_EN length in clocks; 0 means no window
- START  out  1  one-cycle pulse to TX_Switch.START
- RX_EN  out  1  receive gate
- BUSY  out  1  high in FIRE and WAIT
- DONE  out  1  one-cycle pulse at normal completion
- shot_cnt  out  REG_WIDTH  shots fired in the current or last sequence

## Operation
- States: IDLE, FIRE, WAIT, FINISH.
- **IDLE**
  - GO=1 latches all inputs into shadow registers and clears shot_cnt.
  - Next state is FIRE if num_shots≠0, otherwise FINISH.
  - Inputs are never re-sampled during a sequence.
- **FIRE** (exactly 1 cycle)
  - START=1, shot_cnt increments, PRI counter loads 1 → WAIT.
- **WAIT**
  - The PRI counter counts up.
  - When the counter reaches pri_eff−1: go to FIRE if shot_cnt<num_shots, otherwise to FINISH.
- **FINISH** (1 cycle): DONE=1 → IDLE.
- **PRI arithmetic**
  - min_pri = init_delay + tx_len + damp_len + 2. Compute it at PRI_WIDTH with zero-extended operands; it cannot overflow.
  - pri_eff = max(pri_len, min_pri).
  - The comparison is done once, at GO.
- **RX window**
  - For a START in cycle t, RX_EN=1 for cycles t+rx_delay … t+rx_delay+rx_len−1.
  - The window is clipped to cycles ≤ t+pri_eff−1, so it never overlaps the next shot, or FINISH after the last shot.
  - rx_delay=0 makes RX_EN coincide with START.
  - A window that would start at or after pri_eff never asserts.
- **GO handling**: GO in FIRE, WAIT or FINISH is ignored.
- **ABORT**
  - Next cycle: IDLE, with START=0, RX_EN=0, BUSY=0.
  - No DONE pulse; shot_cnt holds its value.
  - ABORT has priority over GO in the same cycle.
- **RESET**: overrides everything; clears all state, mid-sequence included.

## Timing
- Reset values: START=0, RX_EN=0, BUSY=0, DONE=0, shot_cnt=0, state=IDLE.
- All outputs are registered.
- GO sampled in cycle k → START and BUSY high in cycle k+1.
- Shot n (1-based) START at cycle k+1+(n−1)·pri_eff.
- DONE at cycle k+1+num_shots·pri_eff; BUSY low in that cycle; IDLE, and GO accepted, from the following cycle.
- num_shots=0: DONE at k+1, no START, BUSY stays low.
- ABORT sampled in cycle a → all outputs low in cycle a+1.

## Structure
- Shared package (tx_pkg) holds:
  - the state enumeration;
  - TX_PRI_OVERHEAD = 2;
  - the REG_WIDTH default, shared with TX_Switch.
- One sub-module, rx_gate_gen:
  - takes a start strobe (START), rx_delay, rx_len, pri_eff and a clear input;
  - owns its own offset counter and produces RX_EN;
  - clear is driven by ABORT/RESET.
- The top level holds the FSM, the shadow registers, the PRI counter and the min_pri/max logic.

## Test plan
- init_delay=5, tx_len=7, damp_len=3, pri_len=40, num_shots=3, GO at cycle 10 → START at 11, 51, 91; DONE at 131; BUSY high 11–130; shot_cnt=3.
- Same setup with pri_len=4 → pri_eff=17; START at 11, 28, 45; DONE at 62.
- pri_len=40, rx_delay=10, rx_len=40, one shot, GO at 10 → RX_EN high 21–50, clipped at t+39; DONE at 51.
- num_shots=0, GO at 10 → DONE at 11 only; no START, BUSY never high. A second GO at 11 (FINISH) is ignored; a GO at 12 is accepted.
- num_shots=5, pri_len=40, ABORT at cycle 60 → START seen only at 11 and 51; all outputs low from 61; no DONE; shot_cnt=2. GO at 70 restarts: START at 71.
- RESET asserted at cycle 30 of a running sequence → all outputs 0 at 31. Changing pri_len mid-sequence (no reset) has no effect on START spacing.
